// File: rtl/inc16.sv
// ----------------------------------------------------------------------------
// inc16 -- registered 16-bit incrementer
//
// Computes i0 + 1 (mod 2^16) through a ripple chain of 16 half adders whose
// carry-in is tied to 1. The sum and the carry-out of bit 15 are captured in
// output registers on each accepted operand. The carry flags the wrap from
// 16'hFFFF to 16'h0000. Sits in the adder library and feeds the
// program-counter / ALU datapath.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   i0         in  16  operand to increment (unsigned)
//   in_valid   in   1  capture strobe; i0 is sampled when high
//   out        out 16  registered i0 + 1 (mod 2^16)
//   carry      out  1  registered carry-out of bit 15 (set only for i0 == FFFF)
//   out_valid  out  1  high for one cycle after each accepted operand
// ----------------------------------------------------------------------------
module inc16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i0,
  input  logic        in_valid,
  output logic [15:0] out,
  output logic        carry,
  output logic        out_valid
);

  logic [15:0] sum;
  logic        cout;

  logic [15:0] out_q,   out_d;
  logic        carry_q, carry_d;
  logic        valid_q, valid_d;

  // Half-adder ripple chain, carry-in fixed at 1.
  always_comb begin
    logic [16:0] c;
    c    = '0;
    sum  = '0;
    c[0] = 1'b1;
    for (int unsigned k = 0; k < 16; k++) begin
      sum[k]  = i0[k] ^ c[k];
      c[k+1]  = i0[k] & c[k];
    end
    cout = c[16];
  end

  // Result registers load only on an accepted operand, so an undriven or X
  // operand presented with in_valid low never reaches out/carry.
  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    valid_d = in_valid;
    if (in_valid) begin
      out_d   = sum;
      carry_d = cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign carry     = carry_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_inc16.sv
module tb_inc16;

  logic        clk;
  logic        rst_n;
  logic [15:0] i0;
  logic        in_valid;
  logic [15:0] out;
  logic        carry;
  logic        out_valid;

  int unsigned tests_run;
  int unsigned tests_failed;

  inc16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i0        (i0),
    .in_valid  (in_valid),
    .out       (out),
    .carry     (carry),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] observed,
                       input logic [16:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Check all three outputs as one tag.
  task automatic check_all(input string tag, input logic [15:0] e_out,
                           input logic e_carry, input logic e_valid);
    check({tag, ".out"},       {1'b0, out},       {1'b0, e_out});
    check({tag, ".carry"},     {16'h0, carry},    {16'h0, e_carry});
    check({tag, ".out_valid"}, {16'h0, out_valid}, {16'h0, e_valid});
  endtask

  // Drive one operand, pass one rising edge, settle 1 time unit past it.
  task automatic step(input logic [15:0] d, input logic v);
    i0       = d;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] m_out;
  logic        m_carry;
  logic        m_valid;
  logic [15:0] rd;
  logic        rv;

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // 1. reset state, then release with in_valid low
    rst_n    = 1'b0;
    in_valid = 1'b0;
    i0       = 16'h0000;
    #1;
    check_all("reset_async", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    i0 = 16'hABCD; in_valid = 1'b1;
    @(posedge clk); #1;
    check_all("reset_held", 16'h0000, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("release_idle", 16'h0000, 1'b0, 1'b0);

    // 2. first operand
    step(16'h0001, 1'b1);
    check_all("inc_0001", 16'h0002, 1'b0, 1'b1);

    // 3. carry propagation patterns
    step(16'h0003, 1'b1);
    check_all("inc_0003", 16'h0004, 1'b0, 1'b1);
    step(16'h00FF, 1'b1);
    check_all("inc_00FF", 16'h0100, 1'b0, 1'b1);
    step(16'h7FFF, 1'b1);
    check_all("inc_7FFF", 16'h8000, 1'b0, 1'b1);
    step(16'hFFFE, 1'b1);
    check_all("inc_FFFE", 16'hFFFF, 1'b0, 1'b1);

    // 4. wrap, then hold with X on i0 while in_valid low
    step(16'hFFFF, 1'b1);
    check_all("wrap_FFFF", 16'h0000, 1'b1, 1'b1);
    step(16'hxxxx, 1'b0);
    check_all("hold_x_idle", 16'h0000, 1'b1, 1'b0);
    step(16'h5A5A, 1'b0);
    check_all("hold_idle2", 16'h0000, 1'b1, 1'b0);

    // 5. back-to-back stream 0..20
    for (int i = 0; i <= 20; i++) begin
      step(16'(i), 1'b1);
      check_all($sformatf("stream_%0d", i), 16'(i + 1), 1'b0, 1'b1);
    end
    step(16'h0000, 1'b0);
    check_all("stream_end", 16'd21, 1'b0, 1'b0);

    // 6. asynchronous reset between edges
    step(16'h1233, 1'b1);
    check_all("pre_reset", 16'h1234, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_mid_cycle", 16'h0000, 1'b0, 1'b0);
    step(16'h4444, 1'b1);
    check_all("reset_blocks_load", 16'h0000, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    step(16'h0041, 1'b1);
    check_all("post_reset_first", 16'h0042, 1'b0, 1'b1);
    step(16'h0000, 1'b0);
    check_all("post_reset_idle", 16'h0042, 1'b0, 1'b0);

    // 7. random operands against a reference model
    m_out   = 16'h0042;
    m_carry = 1'b0;
    m_valid = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      rd = 16'($urandom);
      if ($urandom_range(0, 63) == 0) rd = 16'hFFFF;
      rv = ($urandom_range(0, 3) != 0);
      step(rd, rv);
      if (rv) {m_carry, m_out} = {1'b0, rd} + 17'd1;
      m_valid = rv;
      check("rand.sum",   {carry, out},      {m_carry, m_out});
      check("rand.valid", {16'h0, out_valid}, {16'h0, m_valid});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
